// File: rtl/ice40_hwtest_pkg.sv
// Shared definitions for the ICE40 pin-exerciser test image: pattern width, seed,
// cellular-automaton next-state rule and the checker FSM encoding.
package ice40_hwtest_pkg;

  localparam int unsigned PatWidth = 110;
  localparam logic [PatWidth-1:0] PatSeed = PatWidth'(1) << 27;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCompare,
    StScan
  } chk_state_e;

  // nxt[i] = x[i+1] ^ (x[i] | b[i]); b wraps x[W-1] into bit 0 and leaves bit 1 empty.
  function automatic logic [PatWidth-1:0] nxt(input logic [PatWidth-1:0] x);
    logic [PatWidth-1:0] a;
    logic [PatWidth-1:0] b;
    a = {1'b0, x[PatWidth-1:1]};
    b = {x[PatWidth-3:0], 1'b0, x[PatWidth-1]};
    return a ^ (x | b);
  endfunction

endpackage

// File: rtl/ca_pattern_checker_if.sv
// Pattern/readback inputs and sticky status outputs of the pattern checker.
interface ca_pattern_checker_if
  import ice40_hwtest_pkg::*;
#(
  parameter int unsigned WIDTH = PatWidth,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned IDX_W = 7
);
  logic             step;
  logic [WIDTH-1:0] pattern_out;
  logic [WIDTH-1:0] pattern_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] fail_mask;
  logic [CNT_W-1:0] err_count;
  logic             first_fail_valid;
  logic [IDX_W-1:0] first_fail_idx;
  logic             rule_err;
  logic [CNT_W-1:0] check_count;
  logic [CNT_W-1:0] overrun_count;

  modport master (
    output step, pattern_out, pattern_in,
    input  busy, done, fail_mask, err_count, first_fail_valid, first_fail_idx, rule_err,
           check_count, overrun_count
  );

  modport slave (
    input  step, pattern_out, pattern_in,
    output busy, done, fail_mask, err_count, first_fail_valid, first_fail_idx, rule_err,
           check_count, overrun_count
  );
endinterface

// File: rtl/ca_pattern_checker.sv
// Checks each advanced pin pattern against the generator rule and, after a settle delay,
// against the pin readback; accumulates sticky per-pin failure data.
module ca_pattern_checker
  import ice40_hwtest_pkg::*;
#(
  parameter int unsigned WIDTH  = PatWidth,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned IDX_W  = $clog2(WIDTH)
) (
  input logic                 pclk,
  input logic                 rst,
  ca_pattern_checker_if.slave chk
);

  localparam int unsigned      SetW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SetW-1:0]  SetLast = SetW'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(WIDTH - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             prev_valid_q, prev_valid_d;
  logic [WIDTH-1:0] mismatch_q, mismatch_d;
  logic [SetW-1:0]  set_cnt_q, set_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] fail_mask_q, fail_mask_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             ff_valid_q, ff_valid_d;
  logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
  logic             rule_err_q, rule_err_d;
  logic [CNT_W-1:0] check_count_q, check_count_d;
  logic [CNT_W-1:0] overrun_count_q, overrun_count_d;

  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    prev_valid_d    = prev_valid_q;
    mismatch_d      = mismatch_q;
    set_cnt_d       = set_cnt_q;
    idx_d           = idx_q;
    done_d          = 1'b0;
    fail_mask_d     = fail_mask_q;
    err_count_d     = err_count_q;
    ff_valid_d      = ff_valid_q;
    ff_idx_d        = ff_idx_q;
    rule_err_d      = rule_err_q;
    check_count_d   = check_count_q;
    overrun_count_d = overrun_count_q;

    if (chk.step && state_q != StIdle) begin
      // Overrun: drop the running check and restart on the new pattern without a rule check.
      overrun_count_d = sat_inc(overrun_count_q);
      cur_d           = chk.pattern_out;
      prev_valid_d    = 1'b0;
      set_cnt_d       = '0;
      state_d         = StSettle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (chk.step) begin
            cur_d = chk.pattern_out;
            if (prev_valid_q && (chk.pattern_out != nxt(cur_q))) rule_err_d = 1'b1;
            prev_valid_d = 1'b1;
            set_cnt_d    = '0;
            state_d      = StSettle;
          end
        end
        StSettle: begin
          if (set_cnt_q == SetLast) state_d = StCompare;
          else                      set_cnt_d = set_cnt_q + SetW'(1);
        end
        StCompare: begin
          mismatch_d  = chk.pattern_in ^ cur_q;
          fail_mask_d = fail_mask_q | (chk.pattern_in ^ cur_q);
          idx_d       = '0;
          state_d     = StScan;
        end
        StScan: begin
          if (mismatch_q[idx_q]) begin
            err_count_d = sat_inc(err_count_q);
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_idx_d   = idx_q;
            end
          end
          if (idx_q == IdxLast) begin
            done_d        = 1'b1;
            check_count_d = sat_inc(check_count_q);
            state_d       = StIdle;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q         <= StIdle;
      cur_q           <= '0;
      prev_valid_q    <= 1'b0;
      mismatch_q      <= '0;
      set_cnt_q       <= '0;
      idx_q           <= '0;
      done_q          <= 1'b0;
      fail_mask_q     <= '0;
      err_count_q     <= '0;
      ff_valid_q      <= 1'b0;
      ff_idx_q        <= '0;
      rule_err_q      <= 1'b0;
      check_count_q   <= '0;
      overrun_count_q <= '0;
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      prev_valid_q    <= prev_valid_d;
      mismatch_q      <= mismatch_d;
      set_cnt_q       <= set_cnt_d;
      idx_q           <= idx_d;
      done_q          <= done_d;
      fail_mask_q     <= fail_mask_d;
      err_count_q     <= err_count_d;
      ff_valid_q      <= ff_valid_d;
      ff_idx_q        <= ff_idx_d;
      rule_err_q      <= rule_err_d;
      check_count_q   <= check_count_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign chk.busy             = (state_q != StIdle);
  assign chk.done             = done_q;
  assign chk.fail_mask        = fail_mask_q;
  assign chk.err_count        = err_count_q;
  assign chk.first_fail_valid = ff_valid_q;
  assign chk.first_fail_idx   = ff_idx_q;
  assign chk.rule_err         = rule_err_q;
  assign chk.check_count      = check_count_q;
  assign chk.overrun_count    = overrun_count_q;

endmodule

// File: tb/tb_ca_pattern_checker.sv
// Bench for ca_pattern_checker: event-timed behavioural model compared every cycle,
// plus literal expectations for the directed scenarios and a CNT_W=4 saturation instance.
module tb_ca_pattern_checker;
  import ice40_hwtest_pkg::*;

  localparam int unsigned W      = PatWidth;
  localparam int unsigned Settle = 4;
  localparam int          Busy   = Settle + 1 + W;
  localparam int          CntMax = 65535;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  ca_pattern_checker_if #(.WIDTH(W), .CNT_W(16), .IDX_W(7)) bus ();
  ca_pattern_checker_if #(.WIDTH(W), .CNT_W(4), .IDX_W(7)) sat_bus ();

  ca_pattern_checker #(.WIDTH(W), .SETTLE(Settle), .CNT_W(16), .IDX_W(7)) dut (
    .pclk(pclk),
    .rst (rst),
    .chk (bus)
  );

  ca_pattern_checker #(.WIDTH(W), .SETTLE(Settle), .CNT_W(4), .IDX_W(7)) dut_sat (
    .pclk(pclk),
    .rst (rst),
    .chk (sat_bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: timeline of each check measured in edges from the accepted step.
  int         cyc = 0;
  logic       m_active = 0, m_busy = 0, m_known = 0, m_done = 0;
  int         m_end = 0, m_sample = 0;
  logic [W-1:0] m_last = '0, m_mm = '0, m_fail = '0;
  int         m_err = 0, m_chk = 0, m_ovr = 0, m_ffi = 0;
  logic       m_rule = 0, m_ffv = 0;

  function automatic int sat(input int v);
    return (v >= CntMax) ? CntMax : v + 1;
  endfunction

  task automatic model_edge(input logic r, input logic st, input logic [W-1:0] po,
                            input logic [W-1:0] pi);
    int k;
    m_done = 1'b0;
    if (r) begin
      m_active = 0; m_busy = 0; m_known = 0; m_last = '0; m_mm = '0; m_fail = '0;
      m_err = 0; m_chk = 0; m_ovr = 0; m_ffi = 0; m_rule = 0; m_ffv = 0;
      return;
    end
    if (st) begin
      if (m_busy) begin
        m_ovr   = sat(m_ovr);
        m_known = 0;
      end else begin
        if (m_known && (po != nxt(m_last))) m_rule = 1'b1;
        m_known = 1;
      end
      m_last   = po;
      m_sample = cyc + Settle + 1;
      m_end    = cyc + Busy;
      m_active = 1;
    end else if (m_active) begin
      if (cyc == m_sample) begin
        m_mm   = pi ^ m_last;
        m_fail = m_fail | m_mm;
      end else if (cyc > m_sample && cyc <= m_end) begin
        k = cyc - m_sample - 1;
        if (m_mm[k]) begin
          m_err = sat(m_err);
          if (!m_ffv) begin
            m_ffv = 1;
            m_ffi = k;
          end
        end
        if (cyc == m_end) begin
          m_done   = 1;
          m_chk    = sat(m_chk);
          m_active = 0;
        end
      end
    end
    m_busy = m_active && (cyc < m_end);
  endtask

  initial begin
    forever begin
      @(posedge pclk);
      cyc++;
      model_edge(rst, bus.step, bus.pattern_out, bus.pattern_in);
    end
  end

  initial begin
    @(posedge pclk);
    forever begin
      @(negedge pclk);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("fail_mask", bus.fail_mask, m_fail);
      chk("err_count", bus.err_count, m_err);
      chk("first_fail_valid", bus.first_fail_valid, m_ffv);
      chk("first_fail_idx", bus.first_fail_idx, m_ffi);
      chk("rule_err", bus.rule_err, m_rule);
      chk("check_count", bus.check_count, m_chk);
      chk("overrun_count", bus.overrun_count, m_ovr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_step(input logic [W-1:0] po, input logic [W-1:0] pi);
    bus.pattern_out = po;
    bus.pattern_in  = pi;
    bus.step        = 1'b1;
    @(negedge pclk);
    bus.step = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!bus.done && n < Busy + 10) begin
      @(negedge pclk);
      n++;
    end
    total++;
    if (!bus.done) begin
      bad++;
      $display("FAIL %s: done not seen within %0d cycles", nm, n);
    end
  endtask

  task automatic sat_check();
    int n = 0;
    sat_bus.step = 1'b1;
    @(negedge pclk);
    sat_bus.step = 1'b0;
    while (!sat_bus.done && n < Busy + 10) begin
      @(negedge pclk);
      n++;
    end
    total++;
    if (!sat_bus.done) begin
      bad++;
      $display("FAIL sat_done: done not seen within %0d cycles", n);
    end
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] p0, p1, p2, lit, stuck, pat;

  initial begin
    bus.step = 0; bus.pattern_out = '0; bus.pattern_in = '0;
    sat_bus.step = 0; sat_bus.pattern_out = '0; sat_bus.pattern_in = '0;
    tick(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_check_count", bus.check_count, 0);
    chk("rst_fail_mask", bus.fail_mask, 0);
    rst = 1'b0;

    // Pin the rule: seed bit 27 -> bits {26,27,29}.
    lit = '0; lit[26] = 1; lit[27] = 1; lit[29] = 1;
    p0  = PatSeed;
    p1  = nxt(p0);
    chk("rule_seed_next", p1, lit);

    // Clean loopback over three rule-conforming patterns.
    do_step(p0, p0);
    chk("busy_after_step", bus.busy, 1);
    wait_done("clean0");
    tick(1);
    chk("done_one_cycle", bus.done, 0);
    do_step(lit, lit);
    chk("clean_rule_err", bus.rule_err, 0);
    wait_done("clean1");
    tick(1);
    p2 = nxt(lit);
    do_step(p2, p2);
    wait_done("clean2");
    tick(1);
    chk("clean_check_count", bus.check_count, 3);
    chk("clean_fail_mask", bus.fail_mask, 0);
    chk("clean_err_count", bus.err_count, 0);

    // Rule violation: repeat the seed instead of its successor.
    do_reset();
    do_step(PatSeed, PatSeed);
    wait_done("rule0");
    tick(1);
    do_step(PatSeed, PatSeed);
    chk("rule_err_set", bus.rule_err, 1);
    wait_done("rule1");
    tick(1);
    chk("rule_fail_mask", bus.fail_mask, 0);

    // Reset in the middle of SCAN.
    do_step(PatSeed, PatSeed);
    tick(Settle + 1 + 10);
    chk("mid_scan_busy", bus.busy, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("scanrst_busy", bus.busy, 0);
    chk("scanrst_done", bus.done, 0);
    chk("scanrst_check_count", bus.check_count, 0);
    chk("scanrst_rule_err", bus.rule_err, 0);
    tick(Busy);
    chk("scanrst_no_done_count", bus.check_count, 0);

    // Readback stuck-at-0 on pins 5 and 64.
    pat = PatSeed; pat[5] = 1; pat[64] = 1; pat[100] = 1;
    stuck = pat; stuck[5] = 0; stuck[64] = 0;
    lit = '0; lit[5] = 1; lit[64] = 1;
    do_step(pat, stuck);
    wait_done("stuck");
    tick(1);
    chk("stuck_fail_mask", bus.fail_mask, lit);
    chk("stuck_ff_valid", bus.first_fail_valid, 1);
    chk("stuck_ff_idx", bus.first_fail_idx, 5);
    chk("stuck_err_count", bus.err_count, 2);

    // Overrun: second step three edges after the first; second pattern breaks the rule.
    do_reset();
    do_step(PatSeed, PatSeed);
    tick(2);
    do_step(PatSeed, PatSeed);
    chk("ovr_count", bus.overrun_count, 1);
    chk("ovr_no_rule", bus.rule_err, 0);
    wait_done("ovr");
    tick(Busy);
    chk("ovr_check_count", bus.check_count, 1);

    // Step on the final scan edge is an overrun.
    do_reset();
    do_step(PatSeed, PatSeed);
    tick(Busy - 1);
    do_step(lit, lit);
    chk("final_edge_ovr", bus.overrun_count, 1);
    chk("final_edge_no_done", bus.done, 0);
    wait_done("final_edge");
    tick(1);
    chk("final_edge_checks", bus.check_count, 1);

    // 4-bit counters: 110 failing pins per check must hold at 15.
    do_reset();
    sat_bus.pattern_out = '1;
    sat_bus.pattern_in  = '0;
    sat_check();
    chk("sat_err_1", sat_bus.err_count, 15);
    sat_check();
    chk("sat_err_2", sat_bus.err_count, 15);
    chk("sat_check_count", sat_bus.check_count, 2);
    chk("sat_ff_idx", sat_bus.first_fail_idx, 0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
